// File: rtl/rgb_yuv_encoder.sv
// rgb_yuv_encoder
//   Reads packed RGB pixels from the shared single-port SRAM and converts them
//   to BT.601 YUV in 16-bit fractional fixed point. U/V are decimated 2:1
//   horizontally. The Y, U and V segments are written back in the layout the
//   milestone-1 decoder consumes. Each quad of 4 pixels takes a fixed 13 cycles:
//   6 reads, 2 drain cycles, 1 calc cycle and 4 writes.
//
//   Optional macro ENC_UV_AVG_EN: the pair U/V sample is the rounded average
//   of the even and odd pixel. When the macro is undefined, the even pixel's
//   sample is kept.
//
// Ports
//   Clock           system clock
//   Resetn          asynchronous active-low reset
//   Enc_Enable      level start request, held by the top FSM until Enc_Stop
//   SRAM_read_data  read data, valid 2 cycles after its address is registered
//   SRAM_address    registered SRAM address
//   SRAM_write_data registered write data
//   SRAM_we_n       registered active-low write enable
//   Enc_Stop        completion flag, held until Enc_Enable drops
module rgb_yuv_encoder #(
  parameter int          NUM_QUADS      = 19200,
  parameter logic [17:0] Y_START_ADDR   = 18'd0,
  parameter logic [17:0] U_START_ADDR   = 18'd38400,
  parameter logic [17:0] V_START_ADDR   = 18'd57600,
  parameter logic [17:0] RGB_START_ADDR = 18'd146944
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enc_Enable,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Enc_Stop
);

  typedef enum logic [3:0] {
    S_ENC_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RW1, S_RW2,
    S_CALC, S_WY0, S_WY1, S_WU, S_WV, S_ENC_DONE
  } state_t;

  state_t      state, state_n;
  logic [17:0] q, q_n, rgb_cnt, rgb_n;
  logic [17:0] addr_n;
  logic [15:0] wd_n;
  logic        we_n_n, stop_n;

  logic [5:0][15:0] w;        // the six RGB words of the current quad
  logic [3:0][7:0]  y;        // Y of pixels 0..3
  logic [7:0]       u_lo, u_hi, v_lo, v_hi;  // pair samples for pixels 0/1 and 2/3

  // ---------------- control ----------------
  // Outputs are registered from the next state, so the bus reflects a state
  // while the FSM is in it. A read issued in S_RD0 therefore returns data
  // that is captured at the end of S_RD2.
  always_comb begin
    state_n = state;
    q_n     = q;
    rgb_n   = rgb_cnt;
    addr_n  = SRAM_address;
    wd_n    = SRAM_write_data;
    we_n_n  = 1'b1;
    case (state)
      S_ENC_IDLE: if (Enc_Enable) state_n = S_RD0;
      S_RD0:  state_n = S_RD1;
      S_RD1:  state_n = S_RD2;
      S_RD2:  state_n = S_RD3;
      S_RD3:  state_n = S_RD4;
      S_RD4:  state_n = S_RD5;
      S_RD5:  state_n = S_RW1;
      S_RW1:  state_n = S_RW2;
      S_RW2:  state_n = S_CALC;
      S_CALC: state_n = S_WY0;
      S_WY0:  state_n = S_WY1;
      S_WY1:  state_n = S_WU;
      S_WU:   state_n = S_WV;
      S_WV: begin
        if (q == 18'(NUM_QUADS - 1)) state_n = S_ENC_DONE;
        else begin
          q_n     = q + 18'd1;
          state_n = S_RD0;
        end
      end
      S_ENC_DONE: begin
        if (!Enc_Enable) begin
          state_n = S_ENC_IDLE;
          q_n     = '0;
          rgb_n   = '0;
        end
      end
      default: state_n = S_ENC_IDLE;
    endcase

    case (state_n)
      S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: begin
        addr_n = RGB_START_ADDR + rgb_cnt;
        rgb_n  = rgb_cnt + 18'd1;
      end
      S_WY0: begin
        addr_n = Y_START_ADDR + {q[16:0], 1'b0};
        wd_n   = {y[1], y[0]};
        we_n_n = 1'b0;
      end
      S_WY1: begin
        addr_n = Y_START_ADDR + {q[16:0], 1'b1};
        wd_n   = {y[3], y[2]};
        we_n_n = 1'b0;
      end
      S_WU: begin
        addr_n = U_START_ADDR + q;
        wd_n   = {u_hi, u_lo};
        we_n_n = 1'b0;
      end
      S_WV: begin
        addr_n = V_START_ADDR + q;
        wd_n   = {v_hi, v_lo};
        we_n_n = 1'b0;
      end
      default: ;
    endcase
    stop_n = (state_n == S_ENC_DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_ENC_IDLE;
      q               <= '0;
      rgb_cnt         <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Enc_Stop        <= 1'b0;
    end else begin
      state           <= state_n;
      q               <= q_n;
      rgb_cnt         <= rgb_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= wd_n;
      SRAM_we_n       <= we_n_n;
      Enc_Stop        <= stop_n;
    end
  end

  // ---------------- datapath ----------------
  // Pixel select: each pixel is converted the cycle after its last component
  // lands, so the one multiplier bank sees at most one pixel per cycle.
  logic [7:0]        r, g, b;
  logic signed [31:0] rs, gs, bs, acc_y, acc_u, acc_v;
  logic [7:0]        y_c, u_c, v_c;

  function automatic logic [7:0] clip8(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 0)        return 8'd0;
    else if (s > 255) return 8'd255;
    else              return s[7:0];
  endfunction

  always_comb begin
    r = '0; g = '0; b = '0;
    case (state)
      S_RD4:  begin r = w[0][7:0];  g = w[0][15:8]; b = w[1][7:0];  end
      S_RD5:  begin r = w[1][15:8]; g = w[2][7:0];  b = w[2][15:8]; end
      S_RW2:  begin r = w[3][7:0];  g = w[3][15:8]; b = w[4][7:0];  end
      S_CALC: begin r = w[4][15:8]; g = w[5][7:0];  b = w[5][15:8]; end
      default: ;
    endcase
    rs    = $signed({24'd0, r});
    gs    = $signed({24'd0, g});
    bs    = $signed({24'd0, b});
    acc_y = rs * 32'sd16843 + gs * 32'sd33030 + bs * 32'sd6423 + 32'sd1081344;
    acc_u = bs * 32'sd28770 - rs * 32'sd9699 - gs * 32'sd19071 + 32'sd8421376;
    acc_v = rs * 32'sd28770 - gs * 32'sd24117 - bs * 32'sd4653 + 32'sd8421376;
    y_c   = clip8(acc_y);
    u_c   = clip8(acc_u);
    v_c   = clip8(acc_v);
  end

`ifdef ENC_UV_AVG_EN
  logic [7:0] u_e, u_o, v_e, v_o;
  logic [8:0] u_sum, v_sum;
  assign u_sum = {1'b0, u_e} + {1'b0, u_o} + 9'd1;
  assign v_sum = {1'b0, v_e} + {1'b0, v_o} + 9'd1;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      w    <= '0;
      y    <= '0;
      u_lo <= '0; u_hi <= '0; v_lo <= '0; v_hi <= '0;
`ifdef ENC_UV_AVG_EN
      u_e <= '0; u_o <= '0; v_e <= '0; v_o <= '0;
`endif
    end else begin
      case (state)
        S_RD2: w[0] <= SRAM_read_data;
        S_RD3: w[1] <= SRAM_read_data;
        S_RD4: w[2] <= SRAM_read_data;
        S_RD5: w[3] <= SRAM_read_data;
        S_RW1: w[4] <= SRAM_read_data;
        S_RW2: w[5] <= SRAM_read_data;
        default: ;
      endcase
      case (state)
        S_RD4:  y[0] <= y_c;
        S_RD5:  y[1] <= y_c;
        S_RW2:  y[2] <= y_c;
        S_CALC: y[3] <= y_c;
        default: ;
      endcase
`ifdef ENC_UV_AVG_EN
      // Even/odd samples are held, then averaged the cycle after the odd pixel.
      case (state)
        S_RD4, S_RW2: begin u_e <= u_c; v_e <= v_c; end
        S_RD5, S_CALC: begin u_o <= u_c; v_o <= v_c; end
        S_RW1: begin u_lo <= u_sum[8:1]; v_lo <= v_sum[8:1]; end
        S_WY0: begin u_hi <= u_sum[8:1]; v_hi <= v_sum[8:1]; end
        default: ;
      endcase
`else
      // Even pixel carries the pair sample; odd-pixel U/V are dropped.
      case (state)
        S_RD4: begin u_lo <= u_c; v_lo <= v_c; end
        S_RW2: begin u_hi <= u_c; v_hi <= v_c; end
        default: ;
      endcase
`endif
    end
  end

endmodule
